// File: rtl/mem_seq_pkg.sv
// Shared size codes, sequencer state encoding and load-result masking
// for the data-memory access sequencer.
package mem_seq_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Zero-extends the addressed low part of the read word.
    function automatic logic [31:0] load_mask(input logic [31:0] rdata,
                                              input logic [1:0]  size);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = {24'h000000, rdata[7:0]};
            SIZE_HALF: res = {16'h0000, rdata[15:0]};
            default:   res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_store_merge.sv
// Combinational read-modify-write merge: replaces the low byte or half of
// the old memory word with the new store data; word size passes new data.
module store_merge
    import mem_seq_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    always_comb begin
        merged = new_data;
        case (size)
            SIZE_BYTE: merged = {old_word[31:8], new_data[7:0]};
            SIZE_HALF: merged = {old_word[31:16], new_data[15:0]};
            default:   merged = new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multicycle load/store sequencer with read-modify-write for sub-word stores.
// Optional macro ALIGN_CHECK_EN rejects misaligned half/word requests with err.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        size_sel
);

    // A one-bit counter still works when MEM_LATENCY is 1: it never advances.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             is_store_q;
    logic [31:0]      store_data_q;
    logic [31:0]      merged;
    logic             req_err;

    always_comb begin
        req_err = (size == SIZE_RSVD);
`ifdef ALIGN_CHECK_EN
        if ((size == SIZE_HALF && addr[0]) ||
            (size == SIZE_WORD && addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    store_merge u_store_merge (
        .old_word (mem_rdata),
        .new_data (store_data_q),
        .size     (size_sel),
        .merged   (merged)
    );

    always_ff @(posedge clock) begin
        if (state == ST_IDLE && start) begin
            is_store_q   <= is_store;
            store_data_q <= store_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            load_data <= 32'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            size_sel  <= SIZE_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        size_sel <= size;
                        err_q    <= req_err;
                        cnt      <= '0;
                        if (req_err) begin
                            state <= ST_DONE;
                        end else begin
                            mem_addr <= addr;
                            if (is_store && size == SIZE_WORD) begin
                                mem_wdata <= store_data;
                                state     <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (cnt == CNT_LAST) begin
                        if (is_store_q) begin
                            mem_wdata <= merged;
                            state     <= ST_WRITE;
                        end else begin
                            load_data <= load_mask(mem_rdata, size_sel);
                            state     <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign err    = done && err_q;
    assign mem_wr = (state == ST_WRITE);

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multicycle controller that sequences every data-memory load/store of size byte, half or word on behalf of the main control unit.
- Drives the memory port and the load-size selector, and captures the zero-extended load result.
- Performs read-modify-write for sub-word stores.
- Sits between the control FSM and data memory; one access in flight at a time via a start/done handshake.

Parameters:
MEM_LATENCY, 2, cycles from mem_addr valid to mem_rdata valid (>=1)
ADDR_W, 32, address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
is_store  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 reserved
addr  in  ADDR_W  byte address
store_data  in  32  store source; low bits used for byte/half
busy  out  1  high from accept until the DONE cycle, inclusive
done  out  1  one-cycle completion pulse
err  out  1  valid with done; reserved size or misalignment
load_data  out  32  zero-extended load result, held until next load completes
mem_addr  out  ADDR_W  memory address
mem_wr  out  1  memory write strobe
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data
size_sel  out  2  latched size for the load-size unit

Behaviour:
- Reset values (asynchronous): busy 0, done 0, err 0, load_data 0, mem_addr 0, mem_wr 0, mem_wdata 0, size_sel 2'b10; state IDLE; latency counter 0.
- States:
  - IDLE: on start, latch is_store, size, addr, store_data; size_sel <= size.
  - READ: mem_addr = addr_q, mem_wr = 0; counter runs MEM_LATENCY cycles.
  - WRITE: one cycle, mem_wr = 1.
  - DONE: done = 1 for one cycle, then IDLE.
- Transitions from IDLE on accept:
  - size 11 -> DONE with err = 1; no memory access; load_data unchanged.
  - store word -> WRITE.
  - all other requests -> READ.
- Load: on the last READ cycle edge, load_data <= mem_rdata masked per size (byte: low 8 bits, upper 24 zero; half: low 16, upper 16 zero; word: all 32), then DONE.
- Sub-word store: on the last READ cycle, rdata_q <= mem_rdata; WRITE drives mem_wdata = rdata_q with the low 8 (byte) or low 16 (half) bits replaced by store_data_q.
- Word store: mem_wdata = store_data_q.
- Latency, with accept at edge k (done high in cycle k+N):
  - load: N = MEM_LATENCY + 1
  - word store: N = 2
  - byte/half store: N = MEM_LATENCY + 2
- start while busy is ignored and not queued.
- start in the DONE cycle is ignored; a new request is accepted in IDLE at the earliest the cycle after done.
- mem_wr is never high outside WRITE.
- Reset asserted mid-operation: mem_wr drops immediately; the access is abandoned with no done pulse; memory contents are not the block's concern.
- Outside WRITE, mem_addr holds its last value.
- MEM_LATENCY = 1: READ lasts exactly one cycle; the counter width must still be legal.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined:
  - half with addr[0] = 1, or word with addr[1:0] != 0 -> DONE directly with err = 1.
  - No memory access, no mem_wr, load_data unchanged.
- Undefined: no alignment check; misaligned requests execute normally; err is set only for size 11.

Decomposition:
- Package mem_seq_pkg:
  - size constants SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10
  - state typedef (IDLE, READ, WRITE, DONE)
  - function for load masking
- One sub-module, store_merge: combinational (old_word, new_data, size) -> merged word; unit-testable alone.

Test Plan (MEM_LATENCY = 2):
- Load byte: addr 0x10, mem_rdata 0xAABBCCDD -> done 3 cycles after accept, load_data 0x000000DD, err 0, mem_wr never high.
- Load half and word at 0x20, mem_rdata 0x8001F00F -> load_data 0x0000F00F, then 0x8001F00F.
- Store byte: addr 0x30, store_data 0x12345677, old word 0xFFFFFFFF -> one mem_wr cycle with mem_wdata 0xFFFFFF77; done 4 cycles after accept.
- Store word: store_data 0xCAFEBABE -> mem_wr in cycle k+1 with 0xCAFEBABE, no preceding read, done at k+2.
- size 11, plus start pulsed while busy -> done with err 1 and no memory activity; second start ignored, exactly one done.
- Reset asserted during READ of a store -> all outputs to reset values asynchronously, no mem_wr, no done.
- With ALIGN_CHECK_EN: word load at 0x22 -> done at k+1 with err 1 and no access.
